// File: rtl/fetch_stage.sv
// fetch_stage: PC register plus F->D pipeline latch with stall, redirect and one delay slot.
// Optional stall-cycle counter output Stall_Cnt is built when FETCH_STALL_CNT_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Stall,
    input  logic        D_Redirect,
    input  logic [31:0] D_Target,
    input  logic [31:0] IM_Rdata,
    output logic [31:0] IM_Addr,
    output logic [31:0] F_PC,
    output logic [31:0] D_Instr,
    output logic [31:0] D_PC,
`ifdef FETCH_STALL_CNT_EN
    output logic        D_Valid,
    output logic [31:0] Stall_Cnt
`else
    output logic        D_Valid
`endif
);

    logic [31:0] next_pc;
    logic        unused_target_lsbs;

    assign IM_Addr            = F_PC;
    assign unused_target_lsbs = ^D_Target[1:0];

    // Next fetch address: word-aligned redirect target, else sequential (wraps naturally).
    always_comb begin
        next_pc = D_Redirect ? {D_Target[31:2], 2'b00} : F_PC + 32'd4;
    end

    // PC and F->D latch: reset wins, stall freezes everything, otherwise advance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            F_PC    <= {RESET_PC[31:2], 2'b00};
            D_Instr <= 32'h0000_0000;
            D_PC    <= RESET_PC;
            D_Valid <= 1'b0;
        end else if (!Stall) begin
            F_PC    <= next_pc;
            D_Instr <= IM_Rdata;
            D_PC    <= F_PC;
            D_Valid <= 1'b1;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Saturating count of stalled edges since the last reset.
    always_ff @(posedge clk) begin
        if (!reset_n)
            Stall_Cnt <= 32'h0000_0000;
        else if (Stall && Stall_Cnt != 32'hFFFF_FFFF)
            Stall_Cnt <= Stall_Cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset_n, Stall, D_Redirect;
    logic [31:0] D_Target, IM_Rdata, IM_Addr, F_PC, D_Instr, D_PC;
    logic        D_Valid;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] Stall_Cnt;
`endif

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    // Behavioural model state
    logic [31:0] exp_fpc, exp_dpc;
    logic        exp_dvalid;
    longint      exp_scnt;
    int          n_fetched, n_delivered;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign IM_Rdata = mem(IM_Addr);

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .Stall(Stall),
        .D_Redirect(D_Redirect),
        .D_Target(D_Target),
        .IM_Rdata(IM_Rdata),
        .IM_Addr(IM_Addr),
        .F_PC(F_PC),
        .D_Instr(D_Instr),
        .D_PC(D_PC),
`ifdef FETCH_STALL_CNT_EN
        .D_Valid(D_Valid),
        .Stall_Cnt(Stall_Cnt)
`else
        .D_Valid(D_Valid)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the fetch stage must hold after each rising edge.
    always @(posedge clk) begin
        if (reset_n === 1'b0) begin
            started     = 1'b1;
            exp_fpc     = RST_PC;
            exp_dpc     = RST_PC;
            exp_dvalid  = 1'b0;
            exp_scnt    = 0;
        end else if (started && !Stall) begin
            exp_dpc     = exp_fpc;
            exp_dvalid  = 1'b1;
            n_delivered++;
            exp_fpc     = D_Redirect ? (D_Target & 32'hFFFF_FFFC) : exp_fpc + 32'd4;
            n_fetched++;
        end else if (started) begin
            exp_scnt    = (exp_scnt == 64'hFFFF_FFFF) ? exp_scnt : exp_scnt + 1;
        end
    end

    // Compare process: every cycle once reset has been seen.
    always @(negedge clk) begin
        if (started) begin
            chk("F_PC", F_PC, exp_fpc);
            chk("IM_Addr", IM_Addr, exp_fpc);
            chk("D_PC", D_PC, exp_dpc);
            chk("D_Valid", {31'd0, D_Valid}, {31'd0, exp_dvalid});
            chk("D_Instr", D_Instr, exp_dvalid ? mem(exp_dpc) : 32'h0);
            chk("F_PC_align", {30'd0, F_PC[1:0]}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
            chk("Stall_Cnt", Stall_Cnt, exp_scnt[31:0]);
`endif
        end
    end

    task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] t);
        reset_n    = r;
        Stall      = s;
        D_Redirect = d;
        D_Target   = t;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; Stall = 1'b0; D_Redirect = 1'b0; D_Target = 32'h0;
        n_fetched = 0; n_delivered = 0;
        @(negedge clk);
        cyc(0, 1, 1, 32'h5555_5555);
        cyc(0, 0, 0, 0);
        chk("rst_F_PC", F_PC, 32'h3000);
        chk("rst_D_PC", D_PC, 32'h3000);
        chk("rst_D_Instr", D_Instr, 32'h0);
        chk("rst_D_Valid", {31'd0, D_Valid}, 32'd0);
        // free-running fetch
        cyc(1, 0, 0, 0);
        chk("run1_F_PC", F_PC, 32'h3004);
        chk("run1_D_PC", D_PC, 32'h3000);
        chk("run1_D_Instr", D_Instr, 32'hC0DE_3000);
        chk("run1_D_Valid", {31'd0, D_Valid}, 32'd1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("run3_F_PC", F_PC, 32'h300C);
        chk("run3_D_PC", D_PC, 32'h3008);
        cyc(1, 0, 0, 0);
        // stall three edges at F_PC=3010
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0);
            chk("stall_F_PC", F_PC, 32'h3010);
            chk("stall_D_Instr", D_Instr, 32'hC0DE_300C);
        end
        cyc(1, 0, 0, 0);
        chk("unstall_D_PC", D_PC, 32'h3010);
        chk("unstall_F_PC", F_PC, 32'h3014);
        // redirect with delay slot, misaligned target
        cyc(1, 0, 1, 32'h3043);
        chk("redir_D_PC", D_PC, 32'h3014);
        chk("redir_F_PC", F_PC, 32'h3040);
        cyc(1, 0, 0, 0);
        chk("tgt_D_PC", D_PC, 32'h3040);
        chk("tgt_D_Instr", D_Instr, 32'hC0DE_3040);
        // stall beats redirect
        cyc(1, 1, 1, 32'h3100);
        chk("stallredir_F_PC", F_PC, 32'h3044);
        cyc(1, 0, 1, 32'h3100);
        chk("lateredir_F_PC", F_PC, 32'h3100);
        chk("lateredir_D_PC", D_PC, 32'h3044);
        // wrap at top of address space
        cyc(1, 0, 1, 32'hFFFF_FFFF);
        chk("top_F_PC", F_PC, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0);
        chk("wrap_F_PC", F_PC, 32'h0000_0000);
        chk("wrap_D_PC", D_PC, 32'hFFFF_FFFC);
        // reset mid-stall
        cyc(1, 0, 1, 32'h3200);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("pre_rst_F_PC", F_PC, 32'h3200);
        cyc(0, 1, 1, 32'h5000);
        chk("midrst_F_PC", F_PC, 32'h3000);
        chk("midrst_D_Instr", D_Instr, 32'h0);
        chk("midrst_D_Valid", {31'd0, D_Valid}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("midrst_Stall_Cnt", Stall_Cnt, 32'd0);
`endif
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
        chk("post5_F_PC", F_PC, 32'h3000);
        chk("post5_D_Valid", {31'd0, D_Valid}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("post5_Stall_Cnt", Stall_Cnt, 32'd5);
`endif
        cyc(1, 0, 0, 0);
        chk("first_D_PC", D_PC, 32'h3000);
        chk("first_D_Valid", {31'd0, D_Valid}, 32'd1);
        // randomized traffic against the model
        n_fetched = 0; n_delivered = 0;
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(63) != 0, $urandom_range(99) < 30, $urandom_range(99) < 25, $urandom);
        chk("fetch_vs_deliver", n_delivered, n_fetched);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000; the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port Stall, input, 1, hazard stall from the stall unit; freezes F and D.
REQ-005 SHALL have port D_Redirect, input, 1, the branch/jump in D is taken.
REQ-006 SHALL have port D_Target, input, 32, redirect target computed in D.
REQ-007 SHALL have port IM_Rdata, input, 32, instruction word at IM_Addr, combinational.
REQ-008 SHALL have port IM_Addr, output, 32, instruction-memory address, equal to F_PC.
REQ-009 SHALL have port F_PC, output, 32, PC of the instruction in F.
REQ-010 SHALL have port D_Instr, output, 32, instruction latched into D.
REQ-011 SHALL have port D_PC, output, 32, PC of D_Instr.
REQ-012 SHALL have port D_Valid, output, 1, D_Instr is a real fetched instruction, not a reset bubble.

Function
REQ-013 SHALL hold state in three registers (F_PC, D_Instr/D_PC pair, D_Valid); all outputs are registered except IM_Addr, which is a wire from F_PC.
REQ-014 SHALL, on an edge with Stall=0, load F_PC <= D_Redirect ? {D_Target[31:2],2'b00} : F_PC+4.
REQ-015 SHALL, on an edge with Stall=0, load D_Instr <= IM_Rdata, D_PC <= F_PC, D_Valid <= 1.
REQ-016 SHALL, on an edge with Stall=1, hold F_PC, D_Instr, D_PC and D_Valid unchanged.
REQ-017 SHALL give Stall priority over D_Redirect; a redirect with Stall=1 is ignored and takes effect only on the first non-stalled edge on which D_Redirect is still asserted.
REQ-018 SHALL implement one delay slot: the instruction in F when D_Redirect is accepted enters D unchanged; the following fetch is from the target.
REQ-019 SHALL keep F_PC[1:0]=2'b00 at all times; D_Target[1:0] is ignored.
REQ-020 SHALL wrap F_PC+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-021 SHALL give fetch-to-D latency of exactly one non-stalled edge; an instruction with Stall held for N cycles reaches D after N+1 edges.
REQ-022 SHALL accept any number of consecutive stall cycles without losing or duplicating an instruction.

Reset
REQ-023 SHALL, on an edge with reset_n=0, set F_PC=RESET_PC, D_Instr=32'h0000_0000 (nop), D_PC=RESET_PC, D_Valid=0, regardless of Stall and D_Redirect.
REQ-024 SHALL abandon any pending redirect or stall on reset; the first edge with reset_n=1 and Stall=0 latches the RESET_PC word into D.
REQ-025 SHALL not alter state asynchronously; reset_n is sampled only on the rising clk edge.

Configuration
REQ-026 SHALL, with macro FETCH_STALL_CNT_EN defined, add output Stall_Cnt (32) counting edges where reset_n=1 and Stall=1, reset to 0, saturating at 32'hFFFF_FFFF.
REQ-027 SHALL, without FETCH_STALL_CNT_EN, omit Stall_Cnt and its register entirely; all other behaviour identical.

Verification
REQ-028 Reset then 3 free-running edges, IM returns PC-tagged words -> F_PC 3000,3004,3008,300C; D_PC 3000,3004,3008; D_Valid 0 then 1.
REQ-029 F_PC=3010, Stall=1 for 3 edges then 0 -> F_PC stays 3010, D_Instr unchanged 3 edges, then D_PC=3010, F_PC=3014.
REQ-030 D holds beq at 3008, D_Redirect=1, D_Target=3040 -> next edge D_PC=300C (delay slot), F_PC=3040; following edge D_PC=3040.
REQ-031 Stall=1 and D_Redirect=1 with D_Target=3100 on same edge -> F_PC unchanged; next edge Stall=0, D_Redirect=1 -> F_PC=3100.
REQ-032 F_PC=FFFF_FFFC, Stall=0; separately D_Target=3043 -> F_PC=0000_0000; F_PC=3040.
REQ-033 reset_n=0 mid-stall at F_PC=3200 -> F_PC=3000, D_Instr=0, D_Valid=0; with FETCH_STALL_CNT_EN, Stall_Cnt=0 after reset and =5 after 5 stalled edges.
